// File: rtl/ad9866_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad9866_pkg
//  Description : Shared constants and state encoding for the AD9866 SPI
//                register-file responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad9866_pkg;

    localparam int c_frame_w    = 16;
    localparam int c_addr_w     = 5;
    localparam int c_data_w     = 8;
    localparam int c_nregs_def  = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // True when the address refers to an implemented register.
    function automatic logic addr_in_range(input logic [c_addr_w-1:0] a, input int n);
        return ({27'd0, a} < n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync
//  Description : Two-flop single-bit synchronizer with a programmable reset
//                value.
//  Ports       : clk, rst (sync, active-high), d (async in), q (sync out)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ad9866_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ad9866_spi_responder
//  Description : Emulates the AD9866 SPI register file. Oversamples the SPI
//                lines on IF_clk, decodes 16-bit frames (R/nW, 5-bit address,
//                8-bit data), commits writes and shifts out read data.
//  Ports       : IF_clk/IF_rst        - clock, sync active-high reset
//                ad9866_sclk/sen_n/sdio - SPI inputs from the master
//                ad9866_sdo           - read data to the master
//                wr_stb/wr_addr/wr_data - committed-write notification
//                host_addr/host_data  - local read port, 1-cycle latency
//                abort_cnt            - saturating count of aborted frames
//                addr_err             - sticky out-of-range access flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ad9866_spi_responder
    import ad9866_pkg::*;
#(
    parameter int         NREGS      = c_nregs_def,
    parameter logic [7:0] DEFAULT_RD = 8'h00
) (
    input  logic        IF_clk,
    input  logic        IF_rst,
    input  logic        ad9866_sclk,
    input  logic        ad9866_sen_n,
    input  logic        ad9866_sdio,
    output logic        ad9866_sdo,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [7:0]  wr_data,
    input  logic [4:0]  host_addr,
    output logic [7:0]  host_data,
    output logic [7:0]  abort_cnt,
    output logic        addr_err
);

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic w_sclk_s, w_sen_s, w_sdio_s;
    logic r_sclk_d, r_sen_d;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk (IF_clk), .rst (IF_rst), .d (ad9866_sclk),  .q (w_sclk_s)
    );
    spi_sync #(.RST_VAL(1'b1)) u_sync_sen (
        .clk (IF_clk), .rst (IF_rst), .d (ad9866_sen_n), .q (w_sen_s)
    );
    spi_sync #(.RST_VAL(1'b0)) u_sync_sdio (
        .clk (IF_clk), .rst (IF_rst), .d (ad9866_sdio),  .q (w_sdio_s)
    );

    always_ff @(posedge IF_clk) begin
        if (IF_rst) begin
            r_sclk_d <= 1'b0;
            r_sen_d  <= 1'b1;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_sen_d  <= w_sen_s;
        end
    end

    // sclk edges only count while the frame is enabled
    logic w_sclk_rise, w_sclk_fall, w_sen_fall, w_sen_rise;
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d & ~w_sen_s;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d & ~w_sen_s;
    assign w_sen_fall  = ~w_sen_s & r_sen_d;
    assign w_sen_rise  = w_sen_s & ~r_sen_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic [3:0]  r_bit_cnt;
    logic [6:0]  r_shift_in;     // only the last 7 bits are ever needed
    logic [7:0]  r_out_sr;
    logic        r_rnw;
    logic [4:0]  r_addr;
    logic [7:0]  r_regs [NREGS];

    logic w_start, w_sample, w_addr_done, w_frame_done, w_abort, w_shift_out;

    logic [4:0] w_addr_new;
    logic [7:0] w_data_new;
    assign w_addr_new = {r_shift_in[3:0], w_sdio_s};
    assign w_data_new = {r_shift_in[6:0], w_sdio_s};

    always_ff @(posedge IF_clk) begin
        if (IF_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_sample     = 1'b0;
        w_addr_done  = 1'b0;
        w_frame_done = 1'b0;
        w_abort      = 1'b0;
        w_shift_out  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sen_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_INSTR;
                end
            end
            ST_INSTR: begin
                if (w_sen_rise) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == 4'd7) begin
                        w_addr_done = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_sen_rise) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (w_sclk_rise) begin
                        w_sample = 1'b1;
                        if (r_bit_cnt == 4'(c_frame_w - 1)) begin
                            w_frame_done = 1'b1;
                            w_state_nxt  = ST_DONE;
                        end
                    end
                    if (w_sclk_fall && r_rnw) begin
                        w_shift_out = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (w_sen_rise) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge IF_clk) begin
        if (IF_rst) begin
            r_bit_cnt  <= 4'd0;
            r_shift_in <= 7'd0;
            r_out_sr   <= 8'd0;
            r_rnw      <= 1'b0;
            r_addr     <= 5'd0;
            ad9866_sdo <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= 5'd0;
            wr_data    <= 8'd0;
            host_data  <= 8'd0;
            abort_cnt  <= 8'd0;
            addr_err   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            wr_stb <= 1'b0;

            if (w_start) begin
                r_bit_cnt  <= 4'd0;
                r_shift_in <= 7'd0;
            end

            if (w_sample) begin
                r_shift_in <= {r_shift_in[5:0], w_sdio_s};
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end

            // Instruction byte complete: R/nW arrived 7 samples ago
            if (w_addr_done) begin
                r_rnw  <= r_shift_in[6];
                r_addr <= w_addr_new;
                if (addr_in_range(w_addr_new, NREGS)) begin
                    r_out_sr <= r_regs[w_addr_new];
                end else begin
                    r_out_sr <= DEFAULT_RD;
                    addr_err <= 1'b1;
                end
            end

            if (w_shift_out) begin
                ad9866_sdo <= r_out_sr[7];
                r_out_sr   <= {r_out_sr[6:0], 1'b0};
            end

            // sdo is only live while the data phase continues
            if (w_state_nxt != ST_DATA) begin
                ad9866_sdo <= 1'b0;
            end

            if (w_frame_done && !r_rnw && addr_in_range(r_addr, NREGS)) begin
                r_regs[r_addr] <= w_data_new;
                wr_stb         <= 1'b1;
                wr_addr        <= r_addr;
                wr_data        <= w_data_new;
            end

            if (w_abort && (abort_cnt != 8'hFF)) begin
                abort_cnt <= abort_cnt + 8'd1;
            end

            // Reads the pre-commit value when a write lands in the same cycle
            if (addr_in_range(host_addr, NREGS)) begin
                host_data <= r_regs[host_addr];
            end else begin
                host_data <= DEFAULT_RD;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad9866_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad9866_spi_responder
//  Description : Scoreboard bench for ad9866_spi_responder. Expected writes
//                and read bytes are queued by the stimulus; monitors pop and
//                compare when the DUT pulses wr_stb or a read frame ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad9866_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       sen_n = 1'b1;
    logic       sdio = 1'b0;
    logic       sdo;
    logic       wr_stb;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] host_addr = 5'd0;
    logic [7:0] host_data;
    logic [7:0] abort_cnt;
    logic       addr_err;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  rd_obs;
    event        rd_ev;

    always #5 clk = ~clk;

    ad9866_spi_responder #(.NREGS(20), .DEFAULT_RD(8'h00)) dut (
        .IF_clk       (clk),
        .IF_rst       (rst),
        .ad9866_sclk  (sclk),
        .ad9866_sen_n (sen_n),
        .ad9866_sdio  (sdio),
        .ad9866_sdo   (sdo),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .host_addr    (host_addr),
        .host_data    (host_data),
        .abort_cnt    (abort_cnt),
        .addr_err     (addr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every wr_stb cycle must match the next queued write
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr_stb: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
            end else begin
                chk("wr_commit", {wr_addr, wr_data}, exp_wr.pop_front());
            end
        end
    end

    // Read monitor: each completed read frame must match the next queued byte
    initial begin
        forever begin
            @(rd_ev);
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%0h expected none", rd_obs);
            end else begin
                chk("sdo_read_byte", rd_obs, exp_rd.pop_front());
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SPI master, sclk = IF_clk/8. Shifts nbits of word MSB first; captures sdo
    // before rises 9..16. keep_low leaves the frame open.
    task automatic spi_frame(input logic [31:0] word, input int nbits, input bit keep_low);
        logic [7:0] cap;
        cap   = 8'd0;
        sen_n = 1'b0;
        wait_clk(4);
        for (int k = 0; k < nbits; k++) begin
            sdio = word[nbits-1-k];
            wait_clk(4);
            if (k >= 8 && k < 16) cap = {cap[6:0], sdo};
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        if (!keep_low) begin
            wait_clk(6);
            sen_n = 1'b1;
            sdio  = 1'b0;
            wait_clk(8);
            if (nbits == 16 && word[15]) begin
                rd_obs = cap;
                -> rd_ev;
            end
        end
    endtask

    task automatic host_rd(input logic [4:0] a, input logic [7:0] exp, input string name);
        host_addr = a;
        wait_clk(1);
        chk(name, host_data, exp);
    endtask

    task automatic quick_abort();
        sen_n = 1'b0;
        wait_clk(4);
        sen_n = 1'b1;
        wait_clk(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);

        // Reset state
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_host_data", host_data, 0);
        chk("rst_abort_cnt", abort_cnt, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_sdo", sdo, 0);

        // Write 0x0A <- 0x5C
        exp_wr.push_back({5'h0A, 8'h5C});
        spi_frame(32'h0A5C, 16, 1'b0);
        chk("wr_addr_hold", wr_addr, 32'h0A);
        chk("wr_data_hold", wr_data, 32'h5C);
        host_rd(5'h0A, 8'h5C, "host_reg0A");

        // Readback of 0x0A: bits 0,1,0,1,1,1,0,0
        exp_rd.push_back(8'h5C);
        spi_frame(32'h8A00, 16, 1'b0);
        chk("sdo_idle_after_read", sdo, 0);

        // Abort: seed reg 3, then cut 0x0333 off after 11 bits
        exp_wr.push_back({5'h03, 8'h11});
        spi_frame(32'h0311, 16, 1'b0);
        spi_frame(32'h0333 >> 5, 11, 1'b0);
        chk("abort_cnt_1", abort_cnt, 1);
        host_rd(5'h03, 8'h11, "host_reg03_kept");

        // Out-of-range write and read
        spi_frame(32'h1F77, 16, 1'b0);
        chk("addr_err_set", addr_err, 1);
        exp_rd.push_back(8'h00);
        spi_frame(32'h9F00, 16, 1'b0);
        host_rd(5'h1F, 8'h00, "host_oor_default");

        // Overrun: 20 pulses, only the first 16 bits count
        exp_wr.push_back({5'h0D, 8'hA6});
        spi_frame({12'd0, 16'h0DA6, 4'hF}, 20, 1'b0);
        host_rd(5'h0D, 8'hA6, "host_reg0D_overrun");
        chk("abort_cnt_after_overrun", abort_cnt, 1);

        // Saturation: 300 aborts in total
        for (int i = 0; i < 253; i++) quick_abort();
        chk("abort_cnt_254", abort_cnt, 32'hFE);
        for (int i = 0; i < 46; i++) quick_abort();
        chk("abort_cnt_sat", abort_cnt, 32'hFF);

        // Reset mid-frame, frame is dropped without counting an abort
        spi_frame(32'h0255 >> 6, 10, 1'b1);
        rst = 1'b1;
        wait_clk(3);
        sen_n = 1'b1;
        sdio  = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        chk("midrst_abort_cnt", abort_cnt, 0);
        chk("midrst_addr_err", addr_err, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_sdo", sdo, 0);
        host_rd(5'h0A, 8'h00, "midrst_reg0A_cleared");

        // Recovery after reset
        exp_wr.push_back({5'h01, 8'h42});
        spi_frame(32'h0142, 16, 1'b0);
        host_rd(5'h01, 8'h42, "host_reg01_recover");
        chk("recover_abort_cnt", abort_cnt, 0);

        wait_clk(4);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ad9866_spi_responder.md
AD9866_SPI_RESPONDER -- requirements
Module: ad9866_spi_responder

Interface
REQ-001 SHALL have parameter NREGS, default 20, the number of implemented 8-bit AD9866 registers (addresses 0..NREGS-1).
REQ-002 SHALL have parameter DEFAULT_RD, default 8'h00, the data returned for reads of unimplemented addresses.
REQ-003 SHALL have port IF_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port IF_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port ad9866_sclk, input, 1: SPI clock from the core's SPI master.
REQ-006 SHALL have port ad9866_sen_n, input, 1: SPI frame enable, active-low.
REQ-007 SHALL have port ad9866_sdio, input, 1: SPI serial data from the master.
REQ-008 SHALL have port ad9866_sdo, output, 1: readback data to the master.
REQ-009 SHALL have port wr_stb, output, 1: single-cycle pulse on each committed register write.
REQ-010 SHALL have port wr_addr, output, 5: address of the last committed write.
REQ-011 SHALL have port wr_data, output, 8: data of the last committed write.
REQ-012 SHALL have port host_addr, input, 5: local register-file read address.
REQ-013 SHALL have port host_data, output, 8: local register-file read data.
REQ-014 SHALL have port abort_cnt, output, 8: count of aborted frames, saturating at 8'hFF.
REQ-015 SHALL have port addr_err, output, 1: sticky flag set by any access to an address >= NREGS.

Function
REQ-016 SHALL pass ad9866_sclk, ad9866_sen_n and ad9866_sdio through 2-flop synchronizers, plus one history flop for edge detection; the input clock is supported up to IF_clk/8.
REQ-017 SHALL use the 16-bit frame format, MSB first: bit15 R/nW (1 = read), bits14:13 ignored, bits12:8 address, bits7:0 data.
REQ-018 SHALL sample sdio on each detected synchronized rising edge of sclk while sen_n is low.
REQ-019 SHALL implement states IDLE, INSTR, DATA and DONE; a falling edge of sen_n moves IDLE to INSTR and clears the 4-bit bit counter.
REQ-020 SHALL move INSTR to DATA on the 8th sampled bit, latching R/nW and the address.
REQ-021 SHALL, on entering DATA for a read, load an 8-bit output shift register with reg[addr], or DEFAULT_RD if addr >= NREGS.
REQ-022 SHALL update ad9866_sdo on each detected sclk falling edge in DATA: first fall drives bit7, then bits 6..0 in order.
REQ-023 SHALL hold ad9866_sdo at 0 outside the read data phase.
REQ-024 SHALL, on the 16th sampled bit of a write with addr < NREGS, update reg[addr], wr_addr and wr_data, and pulse wr_stb exactly one cycle after the sample cycle.
REQ-025 SHALL move to DONE after the 16th sampled bit; DONE ignores further sclk edges and returns to IDLE when sen_n rises.
REQ-026 SHALL treat a sen_n rise in INSTR or DATA as an abort: return to IDLE, no register change, no wr_stb, abort_cnt += 1 (saturating).
REQ-027 SHALL, for a write to addr >= NREGS, perform no register update and no wr_stb, and set addr_err.
REQ-028 SHALL ignore sclk edges while sen_n is high.
REQ-029 SHALL register host_data from reg[host_addr] with 1-cycle latency, returning DEFAULT_RD for out-of-range addresses.
REQ-030 SHALL, when a write commit and a host read of the same address fall in the same cycle, return the old value to host_data (read-before-write).

Reset
REQ-031 SHALL, on IF_rst, put the state machine in IDLE and clear the bit counter and shift registers.
REQ-032 SHALL, on IF_rst, clear all registers to 8'h00 and clear wr_stb, wr_addr, wr_data, host_data, abort_cnt, addr_err and ad9866_sdo.
REQ-033 SHALL, when IF_rst is asserted mid-frame, drop the frame silently without incrementing abort_cnt; afterwards it waits in IDLE for the next sen_n fall.
REQ-034 SHALL preset the synchronizer flops to sclk=0 and sen_n=1 on reset.

Structure
REQ-035 SHALL keep the following constants in shared package ad9866_pkg: frame width 16, address width 5, data width 8, NREGS default, and the state encoding.
REQ-036 SHALL instantiate the synchronizer as sub-module spi_sync (2-flop, 1 bit, reset value parameter), three instances; all other logic is in this module.

Verification
REQ-037 SHALL verify write: frame 0x0A5C at sclk = IF_clk/8 -> one wr_stb, wr_addr 0x0A, wr_data 0x5C; host_addr 0x0A gives host_data 0x5C one cycle later.
REQ-038 SHALL verify readback: after the write above, frame 0x8A00 -> sdo bits over data-phase falls = 0,1,0,1,1,1,0,0; no wr_stb.
REQ-039 SHALL verify abort: sen_n rises after 11 bits of 0x0333 -> reg 0x03 unchanged, abort_cnt 1; 300 aborts -> abort_cnt 0xFF.
REQ-040 SHALL verify out-of-range: write 0x1F77 -> no wr_stb, addr_err 1; read 0x9F00 -> sdo shifts 0x00.
REQ-041 SHALL verify overrun/reset: 20 sclk pulses in one frame -> exactly one commit using the first 16 bits; IF_rst mid-frame -> abort_cnt unchanged, all outputs 0.
